// File: rtl/broadcast_queue_pkg.sv
// Shared defaults and entry layout for the result broadcast queue.
// Contents: depth/width defaults and the packed (tag, data) queue entry.
package broadcast_queue_pkg;

    localparam int BQ_DEPTH  = 8;
    localparam int BQ_TAG_W  = 5;
    localparam int BQ_DATA_W = 32;

    // Storage packs entries as {tag, data}, tag in the upper bits.
    typedef struct packed {
        logic [BQ_TAG_W-1:0]  tag;
        logic [BQ_DATA_W-1:0] data;
    } bq_entry_t;

endpackage

// File: rtl/broadcast_queue_if.sv
// Handshake/result-bus bundle between execution units, arbiter and queue.
// master: drives write ports, allowBroadcast, flush; slave: the queue.
interface broadcast_queue_if
    import broadcast_queue_pkg::*;
#(
    parameter int TAG_W  = BQ_TAG_W,
    parameter int DATA_W = BQ_DATA_W
);
    logic              wr0_valid;
    logic [TAG_W-1:0]  wr0_tag;
    logic [DATA_W-1:0] wr0_data;
    logic              wr0_ready;
    logic              wr1_valid;
    logic [TAG_W-1:0]  wr1_tag;
    logic [DATA_W-1:0] wr1_data;
    logic              wr1_ready;
    logic              allowBroadcast;
    logic              flush;
    logic              queueFull;
    logic              queueEmpty;
    logic              broadcastDataAvailable;
    logic              ongoingBroadcast;
    logic              bcast_valid;
    logic [TAG_W-1:0]  bcast_tag;
    logic [DATA_W-1:0] bcast_data;

    modport master (
        output wr0_valid, wr0_tag, wr0_data,
        output wr1_valid, wr1_tag, wr1_data,
        output allowBroadcast, flush,
        input  wr0_ready, wr1_ready,
        input  queueFull, queueEmpty,
        input  broadcastDataAvailable, ongoingBroadcast,
        input  bcast_valid, bcast_tag, bcast_data
    );

    modport slave (
        input  wr0_valid, wr0_tag, wr0_data,
        input  wr1_valid, wr1_tag, wr1_data,
        input  allowBroadcast, flush,
        output wr0_ready, wr1_ready,
        output queueFull, queueEmpty,
        output broadcastDataAvailable, ongoingBroadcast,
        output bcast_valid, bcast_tag, bcast_data
    );

endinterface

// File: rtl/bq_storage.sv
// Entry array for the broadcast queue: two write ports, one async read.
// Ports: we0/waddr0/wdata0, we1/waddr1/wdata1 writes; raddr -> rdata.
module bq_storage #(
    parameter int DEPTH = 8,
    parameter int W     = 37,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we0,
    input  logic [AW-1:0] waddr0,
    input  logic [W-1:0]  wdata0,
    input  logic          we1,
    input  logic [AW-1:0] waddr1,
    input  logic [W-1:0]  wdata1,
    input  logic [AW-1:0] raddr,
    output logic [W-1:0]  rdata
);

    logic [W-1:0] mem_q [DEPTH];

    // Control never issues both writes to the same slot.
    always_ff @(posedge clk) begin
        if (we0) mem_q[waddr0] <= wdata0;
        if (we1) mem_q[waddr1] <= wdata1;
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/broadcast_queue.sv
// FIFO of completed results, popped one per grant onto the result bus.
// Ports: clk, rst (async active-low), bus (slave side of the bundle).
module broadcast_queue
    import broadcast_queue_pkg::*;
#(
    parameter int DEPTH  = BQ_DEPTH,
    parameter int TAG_W  = BQ_TAG_W,
    parameter int DATA_W = BQ_DATA_W
) (
    input logic              clk,
    input logic              rst,
    broadcast_queue_if.slave bus
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int ENT_W = TAG_W + DATA_W;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    logic [CNT_W-1:0]  count_q, count_d, free;
    logic [PTR_W-1:0]  head_q, head_d;
    logic [PTR_W-1:0]  tail_q, tail_d;
    logic [PTR_W-1:0]  waddr1;
    logic              rdy0, rdy1;
    logic              push0, push1, pop;
    logic [ENT_W-1:0]  rdata;
    logic              bv_q, bv_d;
    logic [TAG_W-1:0]  btag_q, btag_d;
    logic [DATA_W-1:0] bdata_q, bdata_d;

    // Space is judged on registered count only; a same-cycle pop
    // never makes room for a push.
    always_comb begin
        free  = DEPTH_C - count_q;
        rdy0  = !bus.flush && (free >= CNT_W'(1));
        rdy1  = !bus.flush &&
                (bus.wr0_valid ? (free >= CNT_W'(2))
                               : (free >= CNT_W'(1)));
        push0 = bus.wr0_valid && rdy0;
        push1 = bus.wr1_valid && rdy1;
        pop   = bus.allowBroadcast && (count_q != '0) && !bus.flush;
        // Port 1 lands behind port 0 when both push.
        waddr1 = push0 ? tail_q + PTR_W'(1) : tail_q;
    end

    always_comb begin
        count_d = count_q + CNT_W'(push0) + CNT_W'(push1)
                  - CNT_W'(pop);
        head_d  = head_q + PTR_W'(pop);
        tail_d  = tail_q + PTR_W'(push0) + PTR_W'(push1);
        bv_d    = pop;
        btag_d  = btag_q;
        bdata_d = bdata_q;
        if (pop) begin
            btag_d  = rdata[ENT_W-1 -: TAG_W];
            bdata_d = rdata[DATA_W-1:0];
        end
        if (bus.flush) begin
            count_d = '0;
            head_d  = '0;
            tail_d  = '0;
            bv_d    = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q <= '0;
            head_q  <= '0;
            tail_q  <= '0;
            bv_q    <= 1'b0;
            btag_q  <= '0;
            bdata_q <= '0;
        end else begin
            count_q <= count_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            bv_q    <= bv_d;
            btag_q  <= btag_d;
            bdata_q <= bdata_d;
        end
    end

    bq_storage #(
        .DEPTH (DEPTH),
        .W     (ENT_W)
    ) u_storage (
        .clk    (clk),
        .we0    (push0),
        .waddr0 (tail_q),
        .wdata0 ({bus.wr0_tag, bus.wr0_data}),
        .we1    (push1),
        .waddr1 (waddr1),
        .wdata1 ({bus.wr1_tag, bus.wr1_data}),
        .raddr  (head_q),
        .rdata  (rdata)
    );

    // Readies are masked while in reset so nothing looks acceptable.
    assign bus.wr0_ready              = rst && rdy0;
    assign bus.wr1_ready              = rst && rdy1;
    assign bus.queueFull              = (count_q == DEPTH_C);
    assign bus.queueEmpty             = (count_q == '0);
    assign bus.broadcastDataAvailable = (count_q != '0);
    assign bus.ongoingBroadcast       = bv_q;
    assign bus.bcast_valid            = bv_q;
    assign bus.bcast_tag              = btag_q;
    assign bus.bcast_data             = bdata_q;

endmodule

// File: tb/tb_broadcast_queue.sv
// Self-checking bench for broadcast_queue: directed cases plus random
// traffic compared every cycle against a queue-based reference model.
module tb_broadcast_queue;
    import broadcast_queue_pkg::*;

    localparam int DEPTH = BQ_DEPTH;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    broadcast_queue_if bus ();

    broadcast_queue #(.DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    bq_entry_t mq[$];
    bit        m_bv;
    bq_entry_t m_b;
    int        checks   = 0;
    int        failures = 0;
    bit        chk_en   = 0;

    task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    function automatic bit exp_rdy0();
        return rst && !bus.flush && (DEPTH - mq.size() >= 1);
    endfunction

    function automatic bit exp_rdy1();
        int fr;
        fr = DEPTH - mq.size();
        return rst && !bus.flush &&
               (bus.wr0_valid ? (fr >= 2) : (fr >= 1));
    endfunction

    // Reference: queue semantics evaluated at each rising edge.
    task automatic model_step();
        int fr;
        bit a0, a1;
        if (!rst || bus.flush) begin
            mq.delete();
            m_bv = 0;
        end else begin
            fr = DEPTH - mq.size();
            a0 = bus.wr0_valid && (fr >= 1);
            a1 = bus.wr1_valid &&
                 (bus.wr0_valid ? (fr >= 2) : (fr >= 1));
            if (bus.allowBroadcast && mq.size() > 0) begin
                m_b  = mq.pop_front();
                m_bv = 1;
            end else begin
                m_bv = 0;
            end
            if (a0) mq.push_back(bq_entry_t'{tag: bus.wr0_tag,
                                             data: bus.wr0_data});
            if (a1) mq.push_back(bq_entry_t'{tag: bus.wr1_tag,
                                             data: bus.wr1_data});
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("queueEmpty", bus.queueEmpty, mq.size() == 0);
            chk("queueFull", bus.queueFull, mq.size() == DEPTH);
            chk("dataAvail", bus.broadcastDataAvailable, mq.size() != 0);
            chk("bcast_valid", bus.bcast_valid, m_bv);
            chk("ongoing", bus.ongoingBroadcast, m_bv);
            chk("wr0_ready", bus.wr0_ready, exp_rdy0());
            chk("wr1_ready", bus.wr1_ready, exp_rdy1());
            if (m_bv) begin
                chk("bcast_tag", bus.bcast_tag, m_b.tag);
                chk("bcast_data", bus.bcast_data, m_b.data);
            end
        end
    end

    task automatic drv(bit v0, logic [BQ_TAG_W-1:0] t0,
                       logic [BQ_DATA_W-1:0] d0, bit v1,
                       logic [BQ_TAG_W-1:0] t1,
                       logic [BQ_DATA_W-1:0] d1, bit ab, bit fl);
        bus.wr0_valid      = v0;
        bus.wr0_tag        = t0;
        bus.wr0_data       = d0;
        bus.wr1_valid      = v1;
        bus.wr1_tag        = t1;
        bus.wr1_data       = d1;
        bus.allowBroadcast = ab;
        bus.flush          = fl;
    endtask

    task automatic idle();
        drv(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic step();
        @(posedge clk);
        model_step();
        #2;
    endtask

    initial begin
        int n;
        rst = 1'b0;
        drv(1, 1, 1, 1, 2, 2, 1, 0);
        repeat (2) @(posedge clk);
        #2;
        chk("rst_bv", bus.bcast_valid, 0);
        chk("rst_ongoing", bus.ongoingBroadcast, 0);
        chk("rst_tag", bus.bcast_tag, 0);
        chk("rst_data", bus.bcast_data, 0);
        chk("rst_empty", bus.queueEmpty, 1);
        chk("rst_full", bus.queueFull, 0);
        chk("rst_avail", bus.broadcastDataAvailable, 0);
        chk("rst_rdy0", bus.wr0_ready, 0);
        chk("rst_rdy1", bus.wr1_ready, 0);
        idle();
        rst = 1'b1;
        chk_en = 1;

        // Single push, grant, broadcast two cycles after the push.
        drv(1, 3, 32'hA5A5, 0, 0, 0, 0, 0);
        step();
        chk("t1_avail", bus.broadcastDataAvailable, 1);
        drv(0, 0, 0, 0, 0, 0, 1, 0);
        step();
        chk("t1_bv", bus.bcast_valid, 1);
        chk("t1_tag", bus.bcast_tag, 3);
        chk("t1_data", bus.bcast_data, 32'hA5A5);
        chk("t1_empty", bus.queueEmpty, 1);
        chk("t1_model_bv", m_bv, 1);
        chk("t1_model_tag", m_b.tag, 3);
        idle();
        step();

        // Dual push with one slot free: only port 0 accepted.
        for (int i = 0; i < DEPTH - 1; i++) begin
            drv(1, BQ_TAG_W'(i), 32'h100 + i, 0, 0, 0, 0, 0);
            step();
        end
        drv(1, 7, 32'h107, 1, 31, 32'hDEAD, 0, 0);
        #1;
        chk("t2_rdy0", bus.wr0_ready, 1);
        chk("t2_rdy1", bus.wr1_ready, 0);
        step();
        chk("t2_full", bus.queueFull, 1);
        drv(0, 0, 0, 0, 0, 0, 1, 0);
        for (int i = 0; i < DEPTH; i++) begin
            step();
            chk("t2_drain_tag", bus.bcast_tag, i);
            chk("t2_drain_bv", bus.bcast_valid, 1);
        end
        chk("t2_empty", bus.queueEmpty, 1);
        step();
        chk("t2_no_extra", bus.bcast_valid, 0);
        idle();

        // Fill via alternating ports, then drain back-to-back.
        for (int i = 0; i < DEPTH; i++) begin
            if (i % 2 == 0)
                drv(1, BQ_TAG_W'(i), 32'h200 + i, 0, 0, 0, 0, 0);
            else
                drv(0, 0, 0, 1, BQ_TAG_W'(i), 32'h200 + i, 0, 0);
            step();
        end
        chk("t3_full", bus.queueFull, 1);
        drv(0, 0, 0, 0, 0, 0, 1, 0);
        for (int i = 0; i < DEPTH; i++) begin
            step();
            chk("t3_tag", bus.bcast_tag, i);
            chk("t3_data", bus.bcast_data, 32'h200 + i);
        end
        chk("t3_empty", bus.queueEmpty, 1);
        step();
        chk("t3_grant_empty", bus.bcast_valid, 0);
        idle();

        // count=4, dual push with a pop in the same cycle.
        for (int i = 0; i < 4; i++) begin
            drv(1, BQ_TAG_W'(10 + i), 32'h300 + i, 0, 0, 0, 0, 0);
            step();
        end
        drv(1, 14, 32'h304, 1, 15, 32'h305, 1, 0);
        step();
        chk("t4_bv", bus.bcast_valid, 1);
        chk("t4_tag", bus.bcast_tag, 10);
        chk("t4_model_size", mq.size(), 5);
        drv(0, 0, 0, 0, 0, 0, 1, 0);
        n = 0;
        repeat (8) begin
            step();
            if (bus.bcast_valid) begin
                chk("t4_order", bus.bcast_tag, 11 + n);
                n++;
            end
        end
        chk("t4_count", n, 5);
        idle();

        // Flush with push and grant pending.
        for (int i = 0; i < 5; i++) begin
            drv(1, BQ_TAG_W'(20 + i), 32'h400 + i, 0, 0, 0, 0, 0);
            step();
        end
        drv(1, 25, 32'h405, 1, 26, 32'h406, 1, 1);
        #1;
        chk("t5_rdy0", bus.wr0_ready, 0);
        chk("t5_rdy1", bus.wr1_ready, 0);
        step();
        chk("t5_bv", bus.bcast_valid, 0);
        chk("t5_empty", bus.queueEmpty, 1);
        chk("t5_model_size", mq.size(), 0);
        idle();
        step();

        // Asynchronous reset during a broadcast cycle.
        drv(1, 5, 32'h55, 1, 6, 32'h66, 0, 0);
        step();
        drv(0, 0, 0, 0, 0, 0, 1, 0);
        step();
        chk("t6_bv_before", bus.bcast_valid, 1);
        idle();
        #1;
        rst = 1'b0;
        mq.delete();
        m_bv = 0;
        #1;
        chk("t6_bv", bus.bcast_valid, 0);
        chk("t6_ongoing", bus.ongoingBroadcast, 0);
        chk("t6_empty", bus.queueEmpty, 1);
        @(posedge clk);
        #2;
        rst = 1'b1;

        // Random traffic against the model.
        repeat (3000) begin
            drv(1'($urandom_range(0, 1)), BQ_TAG_W'($urandom),
                $urandom, 1'($urandom_range(0, 1)),
                BQ_TAG_W'($urandom), $urandom,
                1'($urandom_range(0, 2) == 0),
                1'($urandom_range(0, 40) == 0));
            step();
        end
        idle();
        step();
        chk_en = 0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
